// File: rtl/alu_sequencer.sv
// Control/writeback stage in front of the 4-bit ALU: accepts 8-bit instructions,
// drives one-hot ALU strobes from registered state and captures results into acc.
//
// state | meaning
// IDLE  | ready for an instruction, all strobes low
// EXEC  | single-cycle op: strobe for one cycle, writeback at exit
// SLOAD | LSR high, ALU shift register loads op_a
// SHIFT | LSH or RSH high, writeback of shifted value at exit
module alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic [3:0] alu_result,
    input  logic       alu_overflow,
    input  logic       alu_shift_flag,
    output logic       ADD,
    output logic       SUB,
    output logic       LSR,
    output logic       LSH,
    output logic       RSH,
    output logic       AND,
    output logic       OR,
    output logic       XOR,
    output logic       INV,
    output logic       CLR,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [3:0] acc,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic       done,
    output logic       illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_SLOAD = 2'd2;
    localparam logic [1:0] S_SHIFT = 2'd3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_INV = 4'h7;
    localparam logic [3:0] OP_CLR = 4'h8;
    localparam logic [3:0] OP_LSH = 4'h9;
    localparam logic [3:0] OP_RSH = 4'hA;

    logic [1:0] r_state;
    logic [3:0] r_op;
    logic [3:0] r_opb;
    logic [3:0] r_acc;
    logic       r_carry;
    logic       r_zero;
    logic       r_done;
    logic       r_illegal;

    logic       w_accept;
    logic       w_is_shift;
    logic       w_illegal_op;

    // ready is gated by reset so it drops asynchronously with the rest of the state
    assign instr_ready  = reset && (r_state == S_IDLE);
    assign w_accept     = instr_valid && instr_ready;
    assign w_is_shift   = (instr[7:4] == OP_LSH) || (instr[7:4] == OP_RSH);
    assign w_illegal_op = (r_op > OP_RSH);

    assign op_a       = r_acc;
    assign op_b       = r_opb;
    assign acc        = r_acc;
    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;
    assign done       = r_done;
    assign illegal    = r_illegal;

    always_comb begin
        ADD = 1'b0;
        SUB = 1'b0;
        LSR = 1'b0;
        LSH = 1'b0;
        RSH = 1'b0;
        AND = 1'b0;
        OR  = 1'b0;
        XOR = 1'b0;
        INV = 1'b0;
        CLR = 1'b0;
        case (r_state)
            S_EXEC: begin
                case (r_op)
                    OP_ADD:  ADD = 1'b1;
                    OP_SUB:  SUB = 1'b1;
                    OP_AND:  AND = 1'b1;
                    OP_OR:   OR  = 1'b1;
                    OP_XOR:  XOR = 1'b1;
                    OP_INV:  INV = 1'b1;
                    OP_CLR:  CLR = 1'b1;
                    default: ;
                endcase
            end
            S_SLOAD: LSR = 1'b1;
            S_SHIFT: begin
                if (r_op == OP_LSH) LSH = 1'b1;
                else                RSH = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NOP;
            r_opb     <= 4'h0;
            r_acc     <= 4'h0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= instr[7:4];
                        r_opb   <= instr[3:0];
                        r_state <= w_is_shift ? S_SLOAD : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    case (r_op)
                        OP_LDI: begin
                            r_acc   <= r_opb;
                            r_carry <= 1'b0;
                            r_zero  <= (r_opb == 4'h0);
                        end
                        OP_ADD, OP_SUB: begin
                            r_acc   <= alu_result;
                            r_carry <= alu_overflow;
                            r_zero  <= (alu_result == 4'h0);
                        end
                        OP_AND, OP_OR, OP_XOR, OP_INV, OP_CLR: begin
                            r_acc   <= alu_result;
                            r_carry <= 1'b0;
                            r_zero  <= (alu_result == 4'h0);
                        end
                        default: r_illegal <= w_illegal_op;
                    endcase
                end
                S_SLOAD: r_state <= S_SHIFT;
                S_SHIFT: begin
                    r_acc   <= alu_result;
                    r_carry <= alu_shift_flag;
                    r_zero  <= (alu_result == 4'h0);
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural 4-bit ALU model, a table of directed
// instructions with hand-computed results, and hand-written corner sequences.
module tb_alu_sequencer;

    localparam logic [9:0] M_ADD = 10'h200;
    localparam logic [9:0] M_SUB = 10'h100;
    localparam logic [9:0] M_LSR = 10'h080;
    localparam logic [9:0] M_LSH = 10'h040;
    localparam logic [9:0] M_RSH = 10'h020;
    localparam logic [9:0] M_AND = 10'h010;
    localparam logic [9:0] M_OR  = 10'h008;
    localparam logic [9:0] M_XOR = 10'h004;
    localparam logic [9:0] M_INV = 10'h002;
    localparam logic [9:0] M_CLR = 10'h001;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [3:0] alu_result;
    logic       alu_overflow;
    logic       alu_shift_flag;
    logic       ADD, SUB, LSR, LSH, RSH, AND, OR, XOR, INV, CLR;
    logic [3:0] op_a, op_b, acc;
    logic       carry_flag, zero_flag, done, illegal;
    logic [9:0] strb;
    logic [3:0] sr;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_shift_flag(alu_shift_flag),
        .ADD(ADD), .SUB(SUB), .LSR(LSR), .LSH(LSH), .RSH(RSH),
        .AND(AND), .OR(OR), .XOR(XOR), .INV(INV), .CLR(CLR),
        .op_a(op_a), .op_b(op_b), .acc(acc), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .done(done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign strb = {ADD, SUB, LSR, LSH, RSH, AND, OR, XOR, INV, CLR};

    // ALU model: combinational result, shift register loaded on LSR
    always @(posedge clk) if (LSR) sr <= op_a;

    always_comb begin
        alu_result     = 4'h0;
        alu_overflow   = 1'b0;
        alu_shift_flag = 1'b0;
        if (ADD) {alu_overflow, alu_result} = {1'b0, op_a} + {1'b0, op_b};
        if (SUB) {alu_overflow, alu_result} = {1'b0, op_a} - {1'b0, op_b};
        if (AND) alu_result = op_a & op_b;
        if (OR)  alu_result = op_a | op_b;
        if (XOR) alu_result = op_a ^ op_b;
        if (INV) alu_result = ~op_a;
        if (CLR) alu_result = 4'h0;
        if (LSH) begin
            alu_result     = {sr[2:0], 1'b0};
            alu_shift_flag = sr[3];
        end
        if (RSH) begin
            alu_result     = {1'b0, sr[3:1]};
            alu_shift_flag = sr[0];
        end
    end

    always @(negedge clk) begin
        if (reset && $countones(strb) > 1) viol++;
        if (instr_ready && strb != 10'h0) viol++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] ins;
        logic [9:0] s1;
        logic [9:0] s2;
        int         lat;
        logic [3:0] acc;
        logic       c;
        logic       z;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [9:0] s1;
        logic [9:0] s2;
        logic [3:0] opa;
        logic [3:0] opb;
        int         lat;
        logic       ill;
        logic       seen;
    } obs_t;

    task automatic wait_ready();
        int n;
        n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic exec(input logic [7:0] ins, output obs_t o);
        o = '{s1: 10'h0, s2: 10'h0, opa: 4'h0, opb: 4'h0, lat: 0, ill: 1'b0, seen: 1'b0};
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        wait_ready();
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 8'h8F;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            o.lat = i;
            if (i == 1) begin
                o.s1  = strb;
                o.opa = op_a;
                o.opb = op_b;
            end
            if (i == 2) o.s2 = strb;
            if (done) begin
                o.ill  = illegal;
                o.seen = 1'b1;
                break;
            end
        end
        if (!o.seen) chk("done_timeout", 0, 1);
    endtask

    vec_t       vt[20];
    obs_t       ob;
    logic [3:0] prev_acc;
    logic [7:0] pat[6];
    int         accepts;

    initial begin
        vt[0]  = '{8'h15, 10'h0,  10'h0,  2, 4'h5, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{8'h23, M_ADD,  10'h0,  2, 4'h8, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{8'h1F, 10'h0,  10'h0,  2, 4'hF, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{8'h21, M_ADD,  10'h0,  2, 4'h0, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{8'h31, M_SUB,  10'h0,  2, 4'hF, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{8'h19, 10'h0,  10'h0,  2, 4'h9, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{8'h90, M_LSR,  M_LSH,  3, 4'h2, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{8'hA0, M_LSR,  M_RSH,  3, 4'h1, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{8'h43, M_AND,  10'h0,  2, 4'h1, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{8'h56, M_OR,   10'h0,  2, 4'h7, 1'b0, 1'b0, 1'b0};
        vt[10] = '{8'h67, M_XOR,  10'h0,  2, 4'h0, 1'b0, 1'b1, 1'b0};
        vt[11] = '{8'h70, M_INV,  10'h0,  2, 4'hF, 1'b0, 1'b0, 1'b0};
        vt[12] = '{8'h80, M_CLR,  10'h0,  2, 4'h0, 1'b0, 1'b1, 1'b0};
        vt[13] = '{8'h16, 10'h0,  10'h0,  2, 4'h6, 1'b0, 1'b0, 1'b0};
        vt[14] = '{8'h2F, M_ADD,  10'h0,  2, 4'h5, 1'b1, 1'b0, 1'b0};
        vt[15] = '{8'hF0, 10'h0,  10'h0,  2, 4'h5, 1'b1, 1'b0, 1'b1};
        vt[16] = '{8'h05, 10'h0,  10'h0,  2, 4'h5, 1'b1, 1'b0, 1'b0};
        vt[17] = '{8'h16, 10'h0,  10'h0,  2, 4'h6, 1'b0, 1'b0, 1'b0};
        vt[18] = '{8'hFF, 10'h0,  10'h0,  2, 4'h6, 1'b0, 1'b0, 1'b1};
        vt[19] = '{8'hB3, 10'h0,  10'h0,  2, 4'h6, 1'b0, 1'b0, 1'b1};

        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 0);
        chk("rst_strobes", strb, 0);
        chk("rst_acc", acc, 0);
        chk("rst_opb", op_b, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_zero", zero_flag, 1);
        chk("rst_done", {done, illegal}, 0);
        reset = 1'b1;
        #1;
        chk("ready_after_release", instr_ready, 1);

        prev_acc = 4'h0;
        foreach (vt[k]) begin
            exec(vt[k].ins, ob);
            chk($sformatf("v%0d_strobe1", k), ob.s1, vt[k].s1);
            chk($sformatf("v%0d_strobe2", k), ob.s2, vt[k].s2);
            chk($sformatf("v%0d_latency", k), ob.lat, vt[k].lat);
            chk($sformatf("v%0d_op_a", k), ob.opa, prev_acc);
            chk($sformatf("v%0d_op_b", k), ob.opb, vt[k].ins[3:0]);
            chk($sformatf("v%0d_acc", k), acc, vt[k].acc);
            chk($sformatf("v%0d_carry", k), carry_flag, vt[k].c);
            chk($sformatf("v%0d_zero", k), zero_flag, vt[k].z);
            chk($sformatf("v%0d_illegal", k), ob.ill, vt[k].ill);
            prev_acc = vt[k].acc;
        end

        // back-to-back with valid held and instr changing every cycle
        pat[0] = 8'h12; pat[1] = 8'h8F; pat[2] = 8'h67;
        pat[3] = 8'h3F; pat[4] = 8'h70; pat[5] = 8'h00;
        accepts = 0;
        @(negedge clk);
        wait_ready();
        for (int i = 0; i < 6; i++) begin
            instr       = pat[i];
            instr_valid = (i < 5);
            if (instr_valid && instr_ready) accepts++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("bp_accepts", accepts, 3);
        chk("bp_acc", acc, 4'hA);
        chk("bp_zero", zero_flag, 0);
        chk("bp_done", done, 1);

        // reset during SHIFT
        exec(8'h19, ob);
        @(negedge clk);
        wait_ready();
        instr       = 8'h90;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_lsh_high", strb, M_LSH);
        reset = 1'b0;
        #1;
        chk("mid_rst_strobes", strb, 0);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", instr_ready, 0);
        chk("mid_rst_zero", zero_flag, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exec(8'h14, ob);
        chk("post_rst_latency", ob.lat, 2);
        chk("post_rst_acc", acc, 4'h4);
        chk("post_rst_zero", zero_flag, 0);

        chk("strobe_overlap_or_idle", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
